// File: rtl/ack_frame_gen.sv
// ack_frame_gen: queues ACK requests and streams each ACK frame into the
// TX byte FIFO after a clean inter-frame gap on the channel.
module ack_frame_gen #(
    parameter logic [7:0] MAC_ADDR    = 8'h04,
    parameter logic [7:0] TYPE_CHAR   = 8'h33,
    parameter int         SEQ_EN      = 0,
    parameter int         QDEPTH      = 4,
    parameter int         SIFS_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ack_req,
    input  logic [7:0]               ack_dest,
    input  logic [7:0]               ack_seq,
    input  logic                     cardet,
    input  logic                     tx_busy,
    input  logic                     byte_ready,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    output logic                     frame_active,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [$clog2(QDEPTH):0]  q_count
);

    localparam int FRAME_BYTES = 3 + SEQ_EN;
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(SIFS_CYCLES + 1);
    localparam int IW = $clog2(FRAME_BYTES);

    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(SIFS_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(SIFS_CYCLES);
    localparam logic [CW-1:0] Q_FULL   = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

    state_t state, state_next;

    logic [7:0]    dest_mem [QDEPTH];
    logic [7:0]    seq_mem  [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic [GW-1:0] gap_cnt;
    logic [IW-1:0] idx;
    logic [7:0]    frame_dest, frame_seq;
    logic [7:0]    next_byte;

    logic full, chan_idle, gap_done, accept, last_accept, push, pop;

    assign full        = (q_count == Q_FULL);
    assign chan_idle   = !cardet && !tx_busy;
    assign gap_done    = (state == WAIT) && chan_idle && (gap_cnt >= GAP_LAST);
    assign accept      = (state == SEND) && byte_valid && byte_ready;
    assign last_accept = accept && (idx == LAST_IDX);
    assign pop         = last_accept;
    // A push that coincides with a pop always fits, even on a full queue.
    assign push        = ack_req && (!full || pop);

    assign frame_active = (state != IDLE);

    // Request queue storage, no reset needed on the data itself.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[wr_ptr] <= ack_dest;
            seq_mem[wr_ptr]  <= ack_seq;
        end
    end

    // Queue pointers, occupancy and drop indication.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
            overflow <= ack_req && !push;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a request arriving on an empty queue starts WAIT at once.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (q_count != '0 || ack_req) state_next = WAIT;
            WAIT:    if (gap_done) state_next = SEND;
            SEND:    if (last_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte that follows the current index within the frame.
    always_comb begin
        next_byte = 8'h00;
        unique case (idx + IW'(1))
            IW'(0):  next_byte = frame_dest;
            IW'(1):  next_byte = MAC_ADDR;
            IW'(2):  next_byte = TYPE_CHAR;
            default: next_byte = frame_seq;
        endcase
    end

    // Gap counting, frame latching and registered byte stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt    <= '0;
            idx        <= '0;
            frame_dest <= 8'h00;
            frame_seq  <= 8'h00;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_accept;
            unique case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (state_next == WAIT) begin
                        if (q_count == '0) begin
                            frame_dest <= ack_dest;
                            frame_seq  <= ack_seq;
                        end else begin
                            frame_dest <= dest_mem[rd_ptr];
                            frame_seq  <= seq_mem[rd_ptr];
                        end
                    end
                end
                WAIT: begin
                    if (!chan_idle)
                        gap_cnt <= '0;
                    else if (gap_cnt != GAP_MAX)
                        gap_cnt <= gap_cnt + GW'(1);
                    if (gap_done) begin
                        idx        <= '0;
                        byte_out   <= frame_dest;
                        byte_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (last_accept) begin
                            byte_out   <= 8'h00;
                            byte_valid <= 1'b0;
                        end else begin
                            idx      <= idx + IW'(1);
                            byte_out <= next_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
